// File: rtl/uart_tx_fsmd_pkg.sv
// Shared definitions for the UART transmitter: state encodings common with the
// receiver controller, default frame geometry and the parity helper.
package uart_tx_fsmd_pkg;

    localparam int DEF_NO_OF_SAMPLES = 16;
    localparam int DEF_DATA_SIZE     = 8;
    localparam int MAX_DATA_SIZE     = 8;

    // Encodings are shared with the receiver controller, so keep values fixed.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_e;

    // Even parity: XOR of the word. Odd parity: XNOR of the word.
    // Zero-extension of narrower words does not change either result.
    function automatic logic parity_of(input logic [MAX_DATA_SIZE-1:0] word,
                                       input logic                     even);
        return even ? (^word) : (~^word);
    endfunction

endpackage

// File: rtl/uart_tx_fsmd_if.sv
// Parallel-side handshake bundle of the UART transmitter.
interface uart_tx_fsmd_if
    import uart_tx_fsmd_pkg::*;
#(
    parameter int data_size = DEF_DATA_SIZE
) ();

    logic                 tick;
    logic                 tx_start;
    logic [data_size-1:0] tx_data;
    logic                 tx;
    logic                 busy;
    logic                 frame_done;

    modport master (
        output tick, tx_start, tx_data,
        input  tx, busy, frame_done
    );

    modport slave (
        input  tick, tx_start, tx_data,
        output tx, busy, frame_done
    );

endinterface

// File: rtl/uart_tx_fsmd_datapath.sv
// Transmitter datapath: shift register, oversampling tick counter, data bit
// counter and latched parity bit. All sequencing decisions come from the FSM.
module uart_tx_fsmd_datapath
    import uart_tx_fsmd_pkg::*;
#(
    parameter int even_parity         = 1,
    parameter int data_size           = DEF_DATA_SIZE,
    parameter int sampling_cntr_width = 4,
    parameter int no_of_samples       = DEF_NO_OF_SAMPLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [data_size-1:0] data_in,
    input  logic                 load,
    input  logic                 cnt_rst,
    input  logic                 cnt_en,
    input  logic                 shift,
    input  logic                 bit_incr,
    output logic                 bit_end,
    output logic                 last_bit,
    output logic                 next_lsb,
    output logic                 parity_bit
);

    localparam int bit_cnt_width = (data_size > 1) ? $clog2(data_size) : 1;
    localparam logic [sampling_cntr_width-1:0] last_sample =
        sampling_cntr_width'(no_of_samples - 1);
    localparam logic [bit_cnt_width-1:0] last_index = bit_cnt_width'(data_size - 1);

    logic [sampling_cntr_width-1:0] cnt_q, cnt_d;
    logic [bit_cnt_width-1:0]       bit_cnt_q, bit_cnt_d;
    logic [data_size-1:0]           shift_q, shift_d;
    logic                           parity_q, parity_d;

    // A bit period ends on the last tick of the current bit; nothing ends in IDLE.
    assign bit_end    = cnt_en && tick && (cnt_q == last_sample);
    assign last_bit   = (bit_cnt_q == last_index);
    // Level of the bit that will be on the wire after this edge's shift.
    assign next_lsb   = shift_d[0];
    assign parity_bit = parity_q;

    // Next-state logic: counters advance only on tick, so tick=0 freezes everything.
    always_comb begin
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;

        if (cnt_rst) begin
            cnt_d     = '0;
            bit_cnt_d = '0;
        end else begin
            if (cnt_en && tick) begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
            end
            if (bit_incr) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        if (load) begin
            shift_d  = data_in;
            parity_d = parity_of(MAX_DATA_SIZE'(data_in), even_parity != 0);
        end else if (shift) begin
            shift_d = shift_q >> 1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
        end
    end

endmodule

// File: rtl/uart_tx_fsmd.sv
// UART transmitter: frame-sequencing FSM with registered outputs driving the
// shift/count datapath. One frame per accepted request, LSB first.
module uart_tx_fsmd
    import uart_tx_fsmd_pkg::*;
#(
    parameter int parity_on           = 1,
    parameter int even_parity         = 1,
    parameter int data_size           = DEF_DATA_SIZE,
    parameter int sampling_cntr_width = 4,
    parameter int no_of_samples       = DEF_NO_OF_SAMPLES
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_fsmd_if.slave  bus
);

    uart_state_e state_q;
    logic        tx_q;
    logic        busy_q;
    logic        frame_done_q;

    logic load, cnt_rst, cnt_en, shift, bit_incr;
    logic bit_end, last_bit, next_lsb, parity_bit;

    // Busy is still high during the frame_done cycle, so a request there is not taken.
    assign load     = (state_q == IDLE) && !busy_q && bus.tx_start;
    assign cnt_rst  = load;
    assign cnt_en   = (state_q != IDLE);
    assign shift    = (state_q == DATA) && bit_end;
    assign bit_incr = shift;

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

    uart_tx_fsmd_datapath #(
        .even_parity         (even_parity),
        .data_size           (data_size),
        .sampling_cntr_width (sampling_cntr_width),
        .no_of_samples       (no_of_samples)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .tick       (bus.tick),
        .data_in    (bus.tx_data),
        .load       (load),
        .cnt_rst    (cnt_rst),
        .cnt_en     (cnt_en),
        .shift      (shift),
        .bit_incr   (bit_incr),
        .bit_end    (bit_end),
        .last_bit   (last_bit),
        .next_lsb   (next_lsb),
        .parity_bit (parity_bit)
    );

    // Frame sequencer; tx is driven one edge ahead so the line never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else if (bus.tx_start) begin
                        busy_q  <= 1'b1;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_q    <= next_lsb;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (!last_bit) begin
                            tx_q <= next_lsb;
                        end else if (parity_on != 0) begin
                            tx_q    <= parity_bit;
                            state_q <= PARITY;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        frame_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fsmd.sv
// Bench for uart_tx_fsmd: three instances (even parity, odd parity, no parity)
// checked clock by clock against a frame-level model of the serial line.
`timescale 1ns/1ps
module tb_uart_tx_fsmd;

    localparam int NS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_v;
    logic [7:0] tx_data_v;
    logic [2:0] start_v;
    logic [2:0] tx_o, busy_o, done_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_fsmd_if #(.data_size(8)) bus0 ();
    uart_tx_fsmd_if #(.data_size(8)) bus1 ();
    uart_tx_fsmd_if #(.data_size(8)) bus2 ();

    assign bus0.tick = tick_v;  assign bus0.tx_start = start_v[0];  assign bus0.tx_data = tx_data_v;
    assign bus1.tick = tick_v;  assign bus1.tx_start = start_v[1];  assign bus1.tx_data = tx_data_v;
    assign bus2.tick = tick_v;  assign bus2.tx_start = start_v[2];  assign bus2.tx_data = tx_data_v;

    assign tx_o   = {bus2.tx, bus1.tx, bus0.tx};
    assign busy_o = {bus2.busy, bus1.busy, bus0.busy};
    assign done_o = {bus2.frame_done, bus1.frame_done, bus0.frame_done};

    uart_tx_fsmd #(.parity_on(1), .even_parity(1), .data_size(8),
                   .sampling_cntr_width(4), .no_of_samples(NS))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    uart_tx_fsmd #(.parity_on(1), .even_parity(0), .data_size(8),
                   .sampling_cntr_width(4), .no_of_samples(NS))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    uart_tx_fsmd #(.parity_on(0), .even_parity(1), .data_size(8),
                   .sampling_cntr_width(4), .no_of_samples(NS))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Line levels of one frame, one entry per bit period: start, data LSB first,
    // optional parity (making the count of ones even/odd), stop.
    function automatic logic [11:0] frame_levels(input int cfg, input logic [7:0] d);
        logic [11:0] lv;
        int          ones;
        lv    = '1;
        lv[0] = 1'b0;
        for (int i = 0; i < 8; i++) lv[i+1] = d[i];
        ones = $countones(d);
        if (cfg == 0)      lv[9] = ((ones % 2) == 1);
        else if (cfg == 1) lv[9] = ((ones % 2) == 0);
        return lv;
    endfunction

    function automatic int frame_bits(input int cfg);
        return (cfg == 2) ? 10 : 11;
    endfunction

    // Caller is 1ns after a rising edge with instance w idle; accepted on next edge.
    task automatic start_frame(input int w, input logic [7:0] d);
        tx_data_v  = d;
        start_v[w] = 1'b1;
        @(posedge clk); #1;
        start_v[w] = 1'b0;
        $display("start dut%0d data=%02h", w, d);
    endtask

    // Follows one frame from the accept edge to the frame_done cycle.
    // tmode: 1 = tick every clk, 4 = tick 1-in-4, otherwise random ticks.
    task automatic check_frame(input int w, input logic [7:0] d, input int tmode,
                               input bit poke, output int clks);
        logic [11:0] lv;
        int          total;
        int          k;
        int          limit;
        logic        t;
        lv    = frame_levels(w, d);
        total = frame_bits(w) * NS;
        limit = total * 8 + 16;
        k     = 0;
        clks  = 0;
        check_eq("tx_low_after_accept", tx_o[w], 0);
        check_eq("busy_after_accept", busy_o[w], 1);
        check_eq("done_after_accept", done_o[w], 0);
        while (k < total && clks < limit) begin
            if (tmode == 1)      t = 1'b1;
            else if (tmode == 4) t = ((clks % 4) == 3);
            else                 t = 1'($urandom_range(0, 1));
            tick_v = t;
            if (poke && clks == 40) begin
                start_v[w] = 1'b1;
                tx_data_v  = 8'hFF;
            end else begin
                tx_data_v  = 8'($urandom);
            end
            @(posedge clk); #1;
            clks++;
            if (t) k++;
            tick_v     = 1'b0;
            start_v[w] = 1'b0;
            check_eq("tx", tx_o[w], (k < total) ? lv[k / NS] : 1'b1);
            check_eq("busy", busy_o[w], 1);
            check_eq("frame_done", done_o[w], (k == total) ? 1 : 0);
        end
        check_eq("frame_ticks", k, total);
        $display("frame dut%0d data=%02h ticks=%0d clks=%0d", w, d, k, clks);
    endtask

    // Cycle after frame_done: pulse gone, busy released, line idle.
    task automatic finish_idle(input int w);
        @(posedge clk); #1;
        check_eq("busy_released", busy_o[w], 0);
        check_eq("done_single_pulse", done_o[w], 0);
        check_eq("tx_idle", tx_o[w], 1);
    endtask

    // Request raised in the frame_done cycle and held one more clk.
    task automatic chain_start(input int w, input logic [7:0] d);
        tx_data_v  = d;
        start_v[w] = 1'b1;
        @(posedge clk); #1;
        check_eq("start_on_done_ignored_busy", busy_o[w], 0);
        check_eq("start_on_done_ignored_tx", tx_o[w], 1);
        @(posedge clk); #1;
        start_v[w] = 1'b0;
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         clks;
        int         w;
        int         tm;
        logic [7:0] d;

        rst       = 1'b1;
        tick_v    = 1'b0;
        start_v   = '0;
        tx_data_v = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("reset_tx", tx_o[i], 1);
            check_eq("reset_busy", busy_o[i], 0);
            check_eq("reset_done", done_o[i], 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Even parity, 0xA5: 11 bits, 176 ticks.
        start_frame(0, 8'hA5);
        check_frame(0, 8'hA5, 1, 1'b0, clks);
        check_eq("a5_frame_clks", clks, 176);
        finish_idle(0);

        // Odd parity corner words.
        start_frame(1, 8'h01);
        check_frame(1, 8'h01, 1, 1'b0, clks);
        finish_idle(1);
        start_frame(1, 8'h00);
        check_frame(1, 8'h00, 1, 1'b0, clks);
        finish_idle(1);

        // No parity: 10 bits, 160 ticks.
        start_frame(2, 8'h3C);
        check_frame(2, 8'h3C, 1, 1'b0, clks);
        check_eq("nopar_frame_clks", clks, 160);
        finish_idle(2);

        // Ignored mid-frame request, then back-to-back request on frame_done.
        start_frame(0, 8'h4E);
        check_frame(0, 8'h4E, 1, 1'b1, clks);
        chain_start(0, 8'h96);
        check_frame(0, 8'h96, 1, 1'b0, clks);
        finish_idle(0);

        // Tick 1-in-4: each bit spans 64 clks.
        start_frame(0, 8'hC3);
        check_frame(0, 8'hC3, 4, 1'b0, clks);
        check_eq("slow_tick_frame_clks", clks, 704);
        finish_idle(0);

        // Asynchronous reset in the middle of DATA.
        start_frame(0, 8'h00);
        tick_v = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        tick_v = 1'b0;
        check_eq("pre_rst_tx_data_bit", tx_o[0], 0);
        check_eq("pre_rst_busy", busy_o[0], 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_tx", tx_o[0], 1);
        check_eq("async_rst_busy", busy_o[0], 0);
        check_eq("async_rst_done", done_o[0], 0);
        @(posedge clk); #1;
        check_eq("rst_hold_done", done_o[0], 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_idle_tx", tx_o[0], 1);
        check_eq("post_rst_idle_done", done_o[0], 0);
        d = 8'($urandom);
        start_frame(0, d);
        check_frame(0, d, 1, 1'b0, clks);
        finish_idle(0);

        // Random words across all three configurations.
        for (int n = 0; n < 120; n++) begin
            w  = int'($urandom_range(0, 2));
            d  = 8'($urandom);
            tm = ($urandom_range(0, 1) == 1) ? 1 : 0;
            start_frame(w, d);
            check_frame(w, d, tm, 1'b0, clks);
            finish_idle(w);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
